// File: rtl/dmem_arb_if.sv
// Bundle of the two requester channels and the single-port SRAM channel
// seen by dmem_arbiter.
interface dmem_arb_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              core_valid;
  logic [ADDR_W-1:0] core_addr;
  logic              core_wen;
  logic              core_ren;
  logic [DATA_W-1:0] core_wdata;
  logic              core_ready;
  logic              core_stall;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              ext_valid;
  logic [ADDR_W-1:0] ext_addr;
  logic              ext_wen;
  logic              ext_ren;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_lock;
  logic              ext_ready;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;
  logic              lock_abort;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic              mem_ren;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  core_valid, core_addr, core_wen, core_ren, core_wdata,
    output core_ready, core_stall, core_rvalid, core_rdata,
    input  ext_valid, ext_addr, ext_wen, ext_ren, ext_wdata, ext_lock,
    output ext_ready, ext_rvalid, ext_rdata, lock_abort,
    output mem_addr, mem_wen, mem_ren, mem_wdata,
    input  mem_rdata
  );

  // Requester + SRAM side.
  modport master (
    output core_valid, core_addr, core_wen, core_ren, core_wdata,
    input  core_ready, core_stall, core_rvalid, core_rdata,
    output ext_valid, ext_addr, ext_wen, ext_ren, ext_wdata, ext_lock,
    input  ext_ready, ext_rvalid, ext_rdata, lock_abort,
    input  mem_addr, mem_wen, mem_ren, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: core MEM stage vs external loader, with
// round-robin ties and bounded ext bursts. DMEM_ARB_STATS_EN adds counters.
module dmem_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MAX_LOCK = 16
`ifdef DMEM_ARB_STATS_EN
  , parameter int CNT_W  = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  dmem_arb_if.slave  bus,
  output logic       state_dbg_o
`ifdef DMEM_ARB_STATS_EN
  , output logic [CNT_W-1:0] stat_conflict
  , output logic [CNT_W-1:0] stat_core_stall
  , output logic [CNT_W-1:0] stat_abort
`endif
);

  // Handshake: a request transfers in the cycle valid & ready are both high;
  // requesters hold their request stable until ready, and ready is raised
  // only for the granted requester.
  typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_e;

  localparam int LW = $clog2(MAX_LOCK + 1);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
  logic [1:0]        rsp_owner_q, rsp_owner_d;
  logic              gnt_core, gnt_ext, abort;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_wen, req_ren, req_rd;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    gnt_core     = 1'b0;
    gnt_ext      = 1'b0;
    abort        = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (bus.core_valid && bus.ext_valid) begin
            gnt_core = last_grant_q;
            gnt_ext  = ~last_grant_q;
          end else begin
            gnt_core = bus.core_valid;
            gnt_ext  = bus.ext_valid;
          end
          if (gnt_ext && bus.ext_lock) begin
            state_d    = S_LOCK;
            lock_cnt_d = LW'(1);
          end
        end
        S_LOCK: begin
          gnt_ext = bus.ext_valid;
          if (gnt_ext) begin
            if (!bus.ext_lock) begin
              state_d    = S_IDLE;
              lock_cnt_d = '0;
            end else if (lock_cnt_q == LW'(MAX_LOCK - 1)) begin
              // This beat would reach the bound: end the burst so the core
              // gets the next tie.
              state_d    = S_IDLE;
              lock_cnt_d = '0;
              abort      = 1'b1;
            end else begin
              lock_cnt_d = lock_cnt_q + LW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (gnt_core || gnt_ext) last_grant_d = gnt_ext;
    end
  end

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    req_wen   = 1'b0;
    req_ren   = 1'b0;
    if (gnt_core) begin
      req_addr  = bus.core_addr;
      req_wdata = bus.core_wdata;
      req_wen   = bus.core_wen;
      req_ren   = bus.core_ren;
    end else if (gnt_ext) begin
      req_addr  = bus.ext_addr;
      req_wdata = bus.ext_wdata;
      req_wen   = bus.ext_wen;
      req_ren   = bus.ext_ren;
    end
  end

  // A write wins over a simultaneous read; only pure reads get a response.
  assign req_rd      = req_ren & ~req_wen;
  assign rsp_owner_d = {gnt_ext & req_rd, gnt_core & req_rd};

  assign bus.mem_addr   = req_addr;
  assign bus.mem_wdata  = req_wdata;
  assign bus.mem_wen    = req_wen;
  assign bus.mem_ren    = req_rd;

  assign bus.core_ready  = gnt_core;
  assign bus.ext_ready   = gnt_ext;
  assign bus.core_stall  = bus.core_valid & ~gnt_core & ~rst;
  assign bus.lock_abort  = abort;
  assign bus.core_rvalid = rsp_owner_q[0] & ~rst;
  assign bus.ext_rvalid  = rsp_owner_q[1] & ~rst;
  assign bus.core_rdata  = bus.core_rvalid ? bus.mem_rdata : '0;
  assign bus.ext_rdata   = bus.ext_rvalid ? bus.mem_rdata : '0;
  assign state_dbg_o     = (state_q == S_LOCK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      lock_cnt_q   <= '0;
      rsp_owner_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      rsp_owner_q  <= rsp_owner_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0] conflict_q, stall_q, abort_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
      stall_q    <= '0;
      abort_q    <= '0;
    end else begin
      if (bus.core_valid && bus.ext_valid && !(&conflict_q)) conflict_q <= conflict_q + CNT_W'(1);
      if (bus.core_stall && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if (abort && !(&abort_q)) abort_q <= abort_q + CNT_W'(1);
    end
  end

  assign stat_conflict   = conflict_q;
  assign stat_core_stall = stall_q;
  assign stat_abort      = abort_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_dmem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic state_dbg;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dmem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_conflict, stat_core_stall, stat_abort;
`endif

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .state_dbg_o(state_dbg)
`ifdef DMEM_ARB_STATS_EN
    , .stat_conflict(stat_conflict)
    , .stat_core_stall(stat_core_stall)
    , .stat_abort(stat_abort)
`endif
  );

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 8) return 64'hDEAD;
    return 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0000_0000_0101_0101);
  endfunction

  // ---------------- SRAM behavioural model (port A) ----------------
  logic [DW-1:0] sram [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) sram[i] <= init_val(i);
    end else if (bus.mem_wen) begin
      sram[bus.mem_addr[6:3]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= bus.mem_ren ? sram[bus.mem_addr[6:3]] : {$urandom, $urandom};
  end

  // ---------------- checking helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic          m_lock = 1'b0;
  logic          m_last = 1'b1;
  int            m_cnt  = 0;
  logic          pend_v = 1'b0;
  logic          pend_own = 1'b0;
  logic [DW-1:0] pend_d = '0;
  logic [DW-1:0] ref_mem [16];
  logic          m_gc = 1'b0;
  logic          m_ge = 1'b0;
  int            cnt_conf = 0, cnt_stall = 0, cnt_abort = 0;

  always @(negedge clk) begin
    logic cv, ev, gc, ge, w, r, ab, any;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    cv = bus.core_valid;
    ev = bus.ext_valid;
    if (rst) begin
      chk1("rst_core_ready", bus.core_ready, 1'b0);
      chk1("rst_ext_ready", bus.ext_ready, 1'b0);
      chk1("rst_core_stall", bus.core_stall, 1'b0);
      chk1("rst_core_rvalid", bus.core_rvalid, 1'b0);
      chk1("rst_ext_rvalid", bus.ext_rvalid, 1'b0);
      chk1("rst_mem_wen", bus.mem_wen, 1'b0);
      chk1("rst_mem_ren", bus.mem_ren, 1'b0);
      chk1("rst_lock_abort", bus.lock_abort, 1'b0);
      chk64("rst_mem_addr", bus.mem_addr, 64'h0);
      m_lock = 1'b0; m_last = 1'b1; m_cnt = 0; pend_v = 1'b0;
      m_gc = 1'b0; m_ge = 1'b0;
      cnt_conf = 0; cnt_stall = 0; cnt_abort = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    end else begin
      // Winner: ext owns the memory during a burst; otherwise a lone
      // requester wins, and a tie goes to whoever did not win last.
      if (m_lock)          begin gc = 1'b0;    ge = ev;      end
      else if (cv && ev)   begin gc = m_last;  ge = !m_last; end
      else                 begin gc = cv;      ge = ev;      end
      any = gc || ge;
      a = gc ? bus.core_addr  : (ge ? bus.ext_addr  : '0);
      d = gc ? bus.core_wdata : (ge ? bus.ext_wdata : '0);
      w = gc ? bus.core_wen   : (ge ? bus.ext_wen   : 1'b0);
      r = gc ? bus.core_ren   : (ge ? bus.ext_ren   : 1'b0);
      ab = ge && m_lock && bus.ext_lock && (m_cnt + 1 == ML);

      chk1("core_ready", bus.core_ready, gc);
      chk1("ext_ready", bus.ext_ready, ge);
      chk1("core_stall", bus.core_stall, cv && !gc);
      chk64("mem_addr", bus.mem_addr, a);
      chk64("mem_wdata", bus.mem_wdata, d);
      chk1("mem_wen", bus.mem_wen, w);
      chk1("mem_ren", bus.mem_ren, r && !w);
      chk1("lock_abort", bus.lock_abort, ab);
      chk1("core_rvalid", bus.core_rvalid, pend_v && !pend_own);
      chk1("ext_rvalid", bus.ext_rvalid, pend_v && pend_own);
      chk64("core_rdata", bus.core_rdata, (pend_v && !pend_own) ? pend_d : 64'h0);
      chk64("ext_rdata", bus.ext_rdata, (pend_v && pend_own) ? pend_d : 64'h0);

      pend_v   = any && r && !w;
      pend_own = ge;
      if (pend_v) pend_d = ref_mem[a[6:3]];
      if (any && w) ref_mem[a[6:3]] = d;
      if (ge) begin
        if (!m_lock) begin
          if (bus.ext_lock) begin m_lock = 1'b1; m_cnt = 1; end
        end else if (!bus.ext_lock || ab) begin
          m_lock = 1'b0; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      if (any) m_last = ge;
      if (cv && ev) cnt_conf++;
      if (cv && !gc) cnt_stall++;
      if (ab) cnt_abort++;
      m_gc = gc;
      m_ge = ge;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic v, input logic [AW-1:0] a, input logic w,
                          input logic r, input logic [DW-1:0] d);
    bus.core_valid = v; bus.core_addr = a; bus.core_wen = w;
    bus.core_ren = r;   bus.core_wdata = d;
  endtask

  task automatic set_ext(input logic v, input logic [AW-1:0] a, input logic w,
                         input logic r, input logic [DW-1:0] d, input logic l);
    bus.ext_valid = v; bus.ext_addr = a; bus.ext_wen = w;
    bus.ext_ren = r;   bus.ext_wdata = d; bus.ext_lock = l;
  endtask

  task automatic idle_all();
    set_core(1'b0, '0, 1'b0, 1'b0, '0);
    set_ext(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] exp_er, exp_ab;
    idle_all();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #2;
    chk1("reset_state_idle", state_dbg, 1'b0);
    chk1("reset_core_ready", bus.core_ready, 1'b0);
    chk1("reset_mem_ren", bus.mem_ren, 1'b0);
    chk1("reset_core_rvalid", bus.core_rvalid, 1'b0);
    step();

    // Core-only read of 0x40.
    set_core(1'b1, 64'h40, 1'b0, 1'b1, '0);
    #2;
    chk1("rd_core_ready", bus.core_ready, 1'b1);
    chk1("rd_mem_ren", bus.mem_ren, 1'b1);
    chk64("rd_mem_addr", bus.mem_addr, 64'h40);
    step();
    idle_all();
    #2;
    chk1("rd_core_rvalid", bus.core_rvalid, 1'b1);
    chk64("rd_core_rdata", bus.core_rdata, 64'hDEAD);
    chk1("rd_ext_rvalid", bus.ext_rvalid, 1'b0);
    step();

    // Tie after reset: core, ext, core.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_core(1'b1, 64'h10, 1'b0, 1'b1, '0);
    set_ext(1'b1, 64'h18, 1'b0, 1'b1, '0, 1'b0);
    #2;
    chk1("tie_c0_stall", bus.core_stall, 1'b0);
    chk1("tie_c0_core_ready", bus.core_ready, 1'b1);
    step(); #2;
    chk1("tie_c1_stall", bus.core_stall, 1'b1);
    chk1("tie_c1_ext_ready", bus.ext_ready, 1'b1);
    step(); #2;
    chk1("tie_c2_core_ready", bus.core_ready, 1'b1);
    step();
    idle_all();
    step();

    // Locked 4-beat ext write burst with the core waiting.
    set_core(1'b1, 64'h48, 1'b0, 1'b1, '0);
    for (int b = 0; b < 4; b++) begin
      set_ext(1'b1, 64'h20 + 64'(b * 8), 1'b1, 1'b0, 64'h1000 + 64'(b), b < 3);
      #2;
      chk1("burst_core_stall", bus.core_stall, 1'b1);
      chk1("burst_ext_ready", bus.ext_ready, 1'b1);
      chk1("burst_no_abort", bus.lock_abort, 1'b0);
      step();
    end
    set_ext(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    #2;
    chk1("burst_core_after", bus.core_ready, 1'b1);
    step();
    idle_all();
    step();
    for (int b = 0; b < 4; b++) chk64("burst_sram", sram[4 + b], 64'h1000 + 64'(b));

    // Lock bound: ext holds lock for 10 beats, core waits.
    exp_er = 12'hDEF;
    exp_ab = 12'h108;
    set_core(1'b1, 64'h58, 1'b0, 1'b1, '0);
    set_ext(1'b1, 64'h50, 1'b0, 1'b1, '0, 1'b1);
    for (int c = 0; c < 12; c++) begin
      #2;
      chk1("bound_ext_ready", bus.ext_ready, exp_er[c]);
      chk1("bound_core_ready", bus.core_ready, !exp_er[c]);
      chk1("bound_lock_abort", bus.lock_abort, exp_ab[c]);
      step();
    end

    // Reset while locked with an ext read pending.
    idle_all();
    rst = 1'b1;
    #2;
    chk1("rstlock_ext_rvalid", bus.ext_rvalid, 1'b0);
    step();
    rst = 1'b0;
    set_core(1'b1, 64'h10, 1'b0, 1'b1, '0);
    set_ext(1'b1, 64'h18, 1'b0, 1'b1, '0, 1'b0);
    #2;
    chk1("rstlock_state_idle", state_dbg, 1'b0);
    chk1("rstlock_core_wins", bus.core_ready, 1'b1);
    chk1("rstlock_ext_wait", bus.ext_ready, 1'b0);
    chk1("rstlock_ext_rvalid2", bus.ext_rvalid, 1'b0);
    step();
    set_core(1'b0, '0, 1'b0, 1'b0, '0);
    #2;
    chk1("rstlock_ext_next", bus.ext_ready, 1'b1);
    step();
    idle_all();
    step();

    // Write and read both set: write wins, no response.
    set_core(1'b1, 64'h8, 1'b1, 1'b1, 64'h55);
    #2;
    chk1("wr_mem_wen", bus.mem_wen, 1'b1);
    chk1("wr_mem_ren", bus.mem_ren, 1'b0);
    step();
    idle_all();
    #2;
    chk1("wr_no_rvalid", bus.core_rvalid, 1'b0);
    step();
    chk64("wr_sram", sram[1], 64'h55);

    // Random traffic under protocol rules.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!bus.core_valid || m_gc)
        set_core($urandom_range(0, 99) < 65, 64'($urandom_range(0, 15) * 8),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                 {$urandom, $urandom});
      if (!bus.ext_valid || m_ge)
        set_ext($urandom_range(0, 99) < 65, 64'($urandom_range(0, 15) * 8),
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                {$urandom, $urandom}, $urandom_range(0, 9) < 7);
      step();
    end
    rst = 1'b0;
    idle_all();
    step();
    step();
`ifdef DMEM_ARB_STATS_EN
    chk64("stat_conflict", 64'(stat_conflict), 64'(cnt_conf));
    chk64("stat_core_stall", 64'(stat_core_stall), 64'(cnt_stall));
    chk64("stat_abort", 64'(stat_abort), 64'(cnt_abort));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
